// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_pkg
// Purpose  : Shared constants for the SPI flash responder: 25-series opcodes,
//            FSM state encoding and status-register bit positions.
// Revision : 1.0  initial release
// ============================================================================
package spi_flash_pkg;

    // 25-series opcodes understood by the responder
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_PAGE = 8'h02;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_WRDI = 8'h04;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    // Responder state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_CMD       = 3'd1;
    localparam state_t ST_ADDR      = 3'd2;
    localparam state_t ST_RD_DATA   = 3'd3;
    localparam state_t ST_PROG_DATA = 3'd4;
    localparam state_t ST_STATUS    = 3'd5;
    localparam state_t ST_IGNORE    = 3'd6;

    // Status register layout: {6'b0, WEL, WIP}
    localparam int STATUS_WIP_BIT = 0;
    localparam int STATUS_WEL_BIT = 1;

    // Assemble the status byte shifted out by RDSR
    function automatic logic [7:0] status_byte(input logic wel, input logic wip);
        logic [7:0] s;
        s                 = 8'h00;
        s[STATUS_WEL_BIT] = wel;
        s[STATUS_WIP_BIT] = wip;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Two-flop synchronizer for an asynchronous SPI pin with registered
//            single-cycle rise/fall pulses (3 clk pin-to-pulse latency).
// Revision : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronize the pin, then compare against the previous synchronized value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
            rise <= sync & ~prev;
            fall <= ~sync & prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Purpose  : SPI mode-0 target emulating a 25-series serial flash (READ,
//            PAGE PROGRAM, WREN, WRDI, RDSR) on top of a byte-wide local
//            memory port. SPI pins are oversampled in the clk domain.
// Revision : 1.0  initial release
// ============================================================================
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int ADDR_BITS    = 12,     // must exceed 8 (page offset is 8 bits)
    parameter int WRITE_CYCLES = 48000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_SPI_CLK,
    input  logic                 i_SPI_MOSI,
    input  logic                 i_SPI_CS,
    output logic                 o_SPI_MISO,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [7:0]           o_mem_wdata,
    output logic                 o_mem_we,
    output logic                 o_mem_re,
    input  logic [7:0]           i_mem_rdata,
    input  logic                 i_mem_ack,
    output logic                 o_wel,
    output logic                 o_wip,
    output logic                 o_underrun
);

    localparam int CNT_W = $clog2(WRITE_CYCLES + 1);

    logic                 sck_rise;
    logic                 sck_fall;
    logic                 cs_rise;
    logic                 cs_fall;
    logic                 mosi_meta;
    logic                 mosi_s;

    state_t               state;
    logic [4:0]           bit_cnt;     // bits received in the current field
    logic [6:0]           shift_in;    // first seven bits of the byte in flight
    logic [ADDR_BITS-1:0] addr;        // current byte address
    logic                 is_prog;     // ADDR phase belongs to PAGE PROGRAM
    logic [7:0]           out_shift;   // byte being shifted out on MISO
    logic                 miso_q;
    logic                 rd_wait;     // read strobe issued, data not yet captured
    logic                 prog_any;    // at least one full byte programmed
    logic [CNT_W-1:0]     wip_cnt;

    logic [7:0]           rx_byte;
    logic [7:0]           tx_src;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (i_SPI_CLK),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    // CS idles high so a reset release never manufactures a select edge
    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (i_SPI_CS),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // MOSI only needs a plain two-flop synchronizer; it is sampled on SCK rise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_meta <= i_SPI_MOSI;
            mosi_s    <= mosi_meta;
        end
    end

    assign rx_byte = {shift_in, mosi_s};

    // A byte whose fetch is still outstanding at its first SCK fall goes out as 0xFF
    assign tx_src = (state == ST_RD_DATA && rd_wait) ? 8'hFF : out_shift;

    assign o_SPI_MISO = (state != ST_IDLE) ? miso_q : 1'bz;

    // Command FSM, memory strobes, WEL/WIP bookkeeping and MISO shifting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= 5'd0;
            shift_in    <= 7'd0;
            addr        <= '0;
            is_prog     <= 1'b0;
            out_shift   <= 8'h00;
            miso_q      <= 1'b0;
            rd_wait     <= 1'b0;
            prog_any    <= 1'b0;
            wip_cnt     <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= 8'h00;
            o_mem_we    <= 1'b0;
            o_mem_re    <= 1'b0;
            o_wel       <= 1'b0;
            o_wip       <= 1'b0;
            o_underrun  <= 1'b0;
        end else begin
            o_mem_we <= 1'b0;
            o_mem_re <= 1'b0;

            if (o_wip) begin
                if (wip_cnt == CNT_W'(1)) begin
                    o_wip   <= 1'b0;
                    wip_cnt <= '0;
                end else begin
                    wip_cnt <= wip_cnt - CNT_W'(1);
                end
            end

            if (rd_wait && i_mem_ack) begin
                out_shift <= i_mem_rdata;
                rd_wait   <= 1'b0;
            end

            // CS rise has priority over any SCK edge seen in the same cycle
            if (cs_rise) begin
                state   <= ST_IDLE;
                bit_cnt <= 5'd0;
                rd_wait <= 1'b0;
                if (state == ST_PROG_DATA && prog_any) begin
                    o_wel   <= 1'b0;
                    o_wip   <= 1'b1;
                    wip_cnt <= CNT_W'(WRITE_CYCLES);
                end
            end else if (cs_fall) begin
                state    <= ST_CMD;
                bit_cnt  <= 5'd0;
                miso_q   <= 1'b0;
                prog_any <= 1'b0;
            end else if (sck_rise) begin
                case (state)
                    ST_CMD: begin
                        shift_in <= rx_byte[6:0];
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= 5'd0;
                            if (o_wip && rx_byte != CMD_RDSR) begin
                                state <= ST_IGNORE;
                            end else begin
                                case (rx_byte)
                                    CMD_READ: begin
                                        state   <= ST_ADDR;
                                        is_prog <= 1'b0;
                                    end
                                    CMD_PAGE: begin
                                        if (o_wel) begin
                                            state   <= ST_ADDR;
                                            is_prog <= 1'b1;
                                        end else begin
                                            state <= ST_IGNORE;
                                        end
                                    end
                                    CMD_WREN: begin
                                        o_wel <= 1'b1;
                                        state <= ST_IGNORE;
                                    end
                                    CMD_WRDI: begin
                                        o_wel <= 1'b0;
                                        state <= ST_IGNORE;
                                    end
                                    CMD_RDSR: begin
                                        state     <= ST_STATUS;
                                        out_shift <= status_byte(o_wel, o_wip);
                                    end
                                    default: state <= ST_IGNORE;
                                endcase
                            end
                        end
                    end
                    ST_ADDR: begin
                        // Only the low ADDR_BITS of the 24-bit address survive the shift
                        addr    <= {addr[ADDR_BITS-2:0], mosi_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= 5'd0;
                            if (is_prog) begin
                                state <= ST_PROG_DATA;
                            end else begin
                                state      <= ST_RD_DATA;
                                o_mem_addr <= {addr[ADDR_BITS-2:0], mosi_s};
                                o_mem_re   <= 1'b1;
                                rd_wait    <= 1'b1;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt    <= 5'd0;
                            addr       <= addr + ADDR_BITS'(1);
                            o_mem_addr <= addr + ADDR_BITS'(1);
                            o_mem_re   <= 1'b1;
                            rd_wait    <= 1'b1;
                        end
                    end
                    ST_PROG_DATA: begin
                        shift_in <= rx_byte[6:0];
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt     <= 5'd0;
                            o_mem_addr  <= addr;
                            o_mem_wdata <= rx_byte;
                            o_mem_we    <= 1'b1;
                            prog_any    <= 1'b1;
                            // Page wrap: only the in-page offset advances
                            addr        <= {addr[ADDR_BITS-1:8], addr[7:0] + 8'd1};
                        end
                    end
                    ST_STATUS: begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt   <= 5'd0;
                            out_shift <= status_byte(o_wel, o_wip);
                        end
                    end
                    default: ;
                endcase
            end else if (sck_fall) begin
                if (state == ST_RD_DATA || state == ST_STATUS) begin
                    miso_q    <= tx_src[7];
                    out_shift <= {tx_src[6:0], 1'b0};
                    if (state == ST_RD_DATA && rd_wait) begin
                        o_underrun <= 1'b1;
                        rd_wait    <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_responder
// Purpose  : Self-checking bench: an SPI master driver, a local memory model
//            with programmable ack delay, and a flash-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_flash_responder;

    localparam int ADDR_BITS    = 12;
    localparam int WRITE_CYCLES = 1000;
    localparam int MEM_SIZE     = 1 << ADDR_BITS;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PAGE = 8'h02;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b1;
    logic                 sck       = 1'b0;
    logic                 mosi      = 1'b0;
    logic                 cs        = 1'b1;
    wire                  miso;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [7:0]           mem_wdata;
    logic                 mem_we;
    logic                 mem_re;
    logic [7:0]           mem_rdata = 8'h00;
    logic                 mem_ack   = 1'b0;
    logic                 wel;
    logic                 wip;
    logic                 underrun;

    // A released MISO floats; the pull-up turns that into a visible 1
    pullup (miso);

    always #5 clk = ~clk;

    spi_flash_responder #(
        .ADDR_BITS    (ADDR_BITS),
        .WRITE_CYCLES (WRITE_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_SPI_CLK   (sck),
        .i_SPI_MOSI  (mosi),
        .i_SPI_CS    (cs),
        .o_SPI_MISO  (miso),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_we    (mem_we),
        .o_mem_re    (mem_re),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack),
        .o_wel       (wel),
        .o_wip       (wip),
        .o_underrun  (underrun)
    );

    int checks = 0;
    int passes = 0;

    logic [7:0]           mem     [MEM_SIZE];  // memory the DUT talks to
    logic [7:0]           ref_mem [MEM_SIZE];  // what the flash should contain
    logic                 ref_wel = 1'b0;
    int                   ack_delay = 1;
    int                   hp = 4;              // SCK half period in clk cycles
    int                   pend = 0;
    logic [7:0]           pdata = 8'h00;
    int                   wip_high = 0;
    logic [ADDR_BITS-1:0] re_q[$];
    logic [ADDR_BITS-1:0] we_addr_q[$];
    logic [7:0]           we_data_q[$];
    logic [7:0]           rx_buf   [8];
    logic [7:0]           page_buf [8];

    // Local memory: answer each read strobe after ack_delay cycles, log strobes
    always @(posedge clk) begin
        mem_ack <= 1'b0;
        if (mem_re) begin
            re_q.push_back(mem_addr);
            pend  <= ack_delay - 1;
            pdata <= mem[mem_addr];
            if (ack_delay == 1) begin
                mem_ack   <= 1'b1;
                mem_rdata <= mem[mem_addr];
            end
        end else if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                mem_ack   <= 1'b1;
                mem_rdata <= pdata;
            end
        end
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_addr_q.push_back(mem_addr);
            we_data_q.push_back(mem_wdata);
        end
        if (wip) wip_high <= wip_high + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic int page_addr(input int base, input int i);
        return ((base % MEM_SIZE) & ~255) | ((base + i) & 255);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(hp);
    endtask

    task automatic cs_high();
        tick(hp);
        cs = 1'b1;
        tick(8);
    endtask

    // Mode 0: MOSI set while SCK low, both sides sample on the rising edge
    task automatic xfer_bits(input int n, input logic [7:0] tx, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - n; i--) begin
            mosi  = tx[i];
            tick(hp);
            rx[i] = miso;
            sck   = 1'b1;
            tick(hp);
            sck   = 1'b0;
        end
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] r;
        xfer_bits(8, op, r);
        xfer_bits(8, a[23:16], r);
        xfer_bits(8, a[15:8], r);
        xfer_bits(8, a[7:0], r);
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        logic [7:0] r;
        cs_low();
        send_hdr(OP_READ, a);
        for (int k = 0; k < n; k++) begin
            xfer_bits(8, 8'h00, r);
            rx_buf[k] = r;
        end
        cs_high();
    endtask

    task automatic do_page(input logic [23:0] a, input int n);
        logic [7:0] r;
        cs_low();
        send_hdr(OP_PAGE, a);
        for (int k = 0; k < n; k++) xfer_bits(8, page_buf[k], r);
        cs_high();
    endtask

    task automatic do_simple(input logic [7:0] op);
        logic [7:0] r;
        cs_low();
        xfer_bits(8, op, r);
        cs_high();
    endtask

    task automatic do_rdsr(input int n);
        logic [7:0] r;
        cs_low();
        xfer_bits(8, OP_RDSR, r);
        for (int k = 0; k < n; k++) begin
            xfer_bits(8, 8'h00, r);
            rx_buf[k] = r;
        end
        cs_high();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        checks++;
        if ({mem_addr, mem_wdata, mem_we, mem_re, wel, wip, underrun} !== '0)
            $display("FAIL reset_outputs: got addr=%h wd=%h we=%b re=%b wel=%b wip=%b ur=%b required all 0",
                     mem_addr, mem_wdata, mem_we, mem_re, wel, wip, underrun);
        else passes++;
        checks++;
        if (miso !== 1'b1) $display("FAIL reset_miso: got %b required released (pulled 1)", miso);
        else passes++;
        reset = 1'b1;
        tick(4);
    endtask

    task automatic test_read_basic();
        int r0;
        mem[12'hABC] = 8'h5A; ref_mem[12'hABC] = 8'h5A;
        mem[12'hABD] = 8'h3C; ref_mem[12'hABD] = 8'h3C;
        ack_delay = 1;
        r0 = re_q.size();
        do_read(24'h000ABC, 2);
        checks++;
        if (rx_buf[0] !== 8'h5A) $display("FAIL read_basic_b0: got %h required 5a", rx_buf[0]);
        else passes++;
        checks++;
        if (rx_buf[1] !== 8'h3C) $display("FAIL read_basic_b1: got %h required 3c", rx_buf[1]);
        else passes++;
        checks++;
        if (re_q.size() < r0 + 2 || re_q[r0] !== 12'hABC || re_q[r0+1] !== 12'hABD)
            $display("FAIL read_basic_addr: got %0d strobes required fetches abc,abd", re_q.size() - r0);
        else passes++;
        checks++;
        if (underrun !== 1'b0) $display("FAIL read_basic_underrun: got %b required 0", underrun);
        else passes++;
    endtask

    task automatic test_page_no_wel();
        int w0;
        w0 = we_addr_q.size();
        page_buf[0] = 8'h11;
        do_page(24'h0001FE, 1);
        checks++;
        if (we_addr_q.size() != w0) $display("FAIL page_no_wel_we: got %0d writes required 0", we_addr_q.size() - w0);
        else passes++;
        checks++;
        if (wel !== ref_wel) $display("FAIL page_no_wel_wel: got %b required %b", wel, ref_wel);
        else passes++;
    endtask

    task automatic test_page_program();
        int w0, r0, h0, pa;
        logic [23:0] ra;
        do_simple(OP_WREN);
        ref_wel = 1'b1;
        checks++;
        if (wel !== ref_wel) $display("FAIL wren_wel: got %b required %b", wel, ref_wel);
        else passes++;
        page_buf[0] = 8'h11; page_buf[1] = 8'h22; page_buf[2] = 8'h33;
        w0 = we_addr_q.size();
        h0 = wip_high;
        do_page(24'h0001FE, 3);
        for (int k = 0; k < 3; k++) begin
            pa = page_addr(24'h0001FE, k);
            ref_mem[pa] = page_buf[k];
            checks++;
            if (we_addr_q.size() <= w0 + k || we_addr_q[w0+k] !== ADDR_BITS'(pa) || we_data_q[w0+k] !== page_buf[k])
                $display("FAIL page_write%0d: got %0d writes required %h@%h", k, we_addr_q.size() - w0, page_buf[k], pa);
            else passes++;
        end
        ref_wel = 1'b0;
        checks++;
        if (wel !== ref_wel || wip !== 1'b1) $display("FAIL page_end: got wel=%b wip=%b required wel=0 wip=1", wel, wip);
        else passes++;
        do_rdsr(2);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rx_buf[k] !== 8'h01) $display("FAIL rdsr_busy%0d: got %h required 01", k, rx_buf[k]);
            else passes++;
        end
        r0 = re_q.size();
        ra = 24'($urandom);
        do_read(ra, 1);
        checks++;
        if (re_q.size() != r0) $display("FAIL read_during_wip: got %0d strobes required 0", re_q.size() - r0);
        else passes++;
        for (int t = 0; t < 3 * WRITE_CYCLES && wip; t++) tick(1);
        tick(2);
        checks++;
        if (wip !== 1'b0 || wip_high - h0 != WRITE_CYCLES)
            $display("FAIL wip_duration: got %0d cycles (wip=%b) required %0d", wip_high - h0, wip, WRITE_CYCLES);
        else passes++;
        do_rdsr(1);
        checks++;
        if (rx_buf[0] !== 8'h00) $display("FAIL rdsr_idle: got %h required 00", rx_buf[0]);
        else passes++;
    endtask

    task automatic test_random_reads();
        logic [23:0] a;
        int n, idx, r0;
        for (int it = 0; it < 6; it++) begin
            a = 24'($urandom);
            if (it == 0) a = 24'h0001FE;
            if (it == 1) a = 24'h000100;
            n         = int'($urandom_range(1, 3));
            ack_delay = int'($urandom_range(1, 2));
            hp        = int'($urandom_range(4, 6));
            r0        = re_q.size();
            do_read(a, n);
            for (int k = 0; k < n; k++) begin
                idx = (int'(a[ADDR_BITS-1:0]) + k) % MEM_SIZE;
                checks++;
                if (rx_buf[k] !== ref_mem[idx])
                    $display("FAIL rand_read%0d_b%0d: got %h required %h at %h", it, k, rx_buf[k], ref_mem[idx], idx);
                else passes++;
                checks++;
                if (re_q.size() <= r0 + k || re_q[r0+k] !== ADDR_BITS'(idx))
                    $display("FAIL rand_fetch%0d_b%0d: got %0d strobes required fetch at %h", it, k, re_q.size() - r0, idx);
                else passes++;
            end
        end
        hp = 4;
        checks++;
        if (underrun !== 1'b0) $display("FAIL rand_underrun: got %b required 0", underrun);
        else passes++;
    endtask

    task automatic test_underrun_wrap();
        int r0;
        hp        = 4;
        ack_delay = 3;
        r0        = re_q.size();
        do_read(24'h000FFF, 2);
        ack_delay = 1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rx_buf[k] !== 8'hFF) $display("FAIL underrun_b%0d: got %h required ff", k, rx_buf[k]);
            else passes++;
        end
        checks++;
        if (re_q.size() < r0 + 2 || re_q[r0] !== 12'hFFF || re_q[r0+1] !== 12'h000)
            $display("FAIL wrap_fetch: got %0d strobes required fetches fff,000", re_q.size() - r0);
        else passes++;
        checks++;
        if (underrun !== 1'b1) $display("FAIL underrun_flag: got %b required 1", underrun);
        else passes++;
    endtask

    task automatic test_abort();
        int w0;
        logic [7:0] r;
        do_simple(OP_WREN);
        ref_wel = 1'b1;
        w0 = we_addr_q.size();
        cs_low();
        send_hdr(OP_PAGE, 24'h000234);
        xfer_bits(5, 8'($urandom), r);
        cs_high();
        checks++;
        if (we_addr_q.size() != w0) $display("FAIL abort_we: got %0d writes required 0", we_addr_q.size() - w0);
        else passes++;
        checks++;
        if (wel !== ref_wel || wip !== 1'b0 || miso !== 1'b1)
            $display("FAIL abort_state: got wel=%b wip=%b miso=%b required wel=1 wip=0 miso released", wel, wip, miso);
        else passes++;
        do_simple(OP_WRDI);
        ref_wel = 1'b0;
        checks++;
        if (wel !== ref_wel) $display("FAIL wrdi_wel: got %b required %b", wel, ref_wel);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int r0;
        logic [7:0] r;
        logic [23:0] a;
        do_simple(OP_WREN);
        r0 = re_q.size();
        cs_low();
        xfer_bits(8, OP_READ, r);
        xfer_bits(8, 8'h00, r);
        xfer_bits(2, 8'hC0, r);
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_addr, mem_wdata, mem_we, mem_re, wel, wip, underrun} !== '0 || miso !== 1'b1)
            $display("FAIL reset_mid: got addr=%h we=%b re=%b wel=%b wip=%b ur=%b miso=%b required reset values",
                     mem_addr, mem_we, mem_re, wel, wip, underrun, miso);
        else passes++;
        ref_wel = 1'b0;
        cs  = 1'b1;
        sck = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(4);
        checks++;
        if (re_q.size() != r0) $display("FAIL reset_mid_re: got %0d strobes required 0", re_q.size() - r0);
        else passes++;
        a = 24'($urandom);
        do_read(a, 1);
        checks++;
        if (rx_buf[0] !== ref_mem[a[ADDR_BITS-1:0]])
            $display("FAIL post_reset_read: got %h required %h", rx_buf[0], ref_mem[a[ADDR_BITS-1:0]]);
        else passes++;
    endtask

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        #2;
        test_reset();
        test_read_basic();
        test_page_no_wel();
        test_page_program();
        test_random_reads();
        test_underrun_wrap();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
